// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access controller: turns EX/MEM loads/stores into req/ack transactions.
// Optional BUSY timeout with bus-error abort is enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_access_stage #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  MemReadIn,
    input  logic                  MemWriteIn,
    input  logic [1:0]            MemSizeIn,
    input  logic                  MemSignedIn,
    input  logic [ADDR_WIDTH-1:0] ALUResultIn,
    input  logic [31:0]           WriteDataIn,
    output logic                  Stall,
    output logic [31:0]           DataMemoryOut,
    output logic                  MisalignOut,
    output logic                  BusError,
    output logic                  MemReq,
    output logic                  MemWe,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [31:0]           MemWData,
    output logic [3:0]            MemByteEn,
    input  logic                  MemAck,
    input  logic [31:0]           MemRData
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e state_q, state_d;

    logic                  access, misaligned, misalign_now, stall, timeout;
    logic [3:0]            byte_en;
    logic [31:0]           wdata_rep, load_data;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;

    logic                  req_q, we_q, berr_q, ld_q, sgn_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q, dout_q;
    logic [3:0]            be_q;
    logic [1:0]            sz_q, lo_q;

    always_comb begin
        access     = MemReadIn | MemWriteIn;
        misaligned = ((MemSizeIn == 2'b01) && ALUResultIn[0]) ||
                     (MemSizeIn[1] && (ALUResultIn[1:0] != 2'b00));
        byte_en    = 4'b1111;
        wdata_rep  = WriteDataIn;
        case (MemSizeIn)
            2'b00: begin
                byte_en   = 4'b0001 << ALUResultIn[1:0];
                wdata_rep = {4{WriteDataIn[7:0]}};
            end
            2'b01: begin
                byte_en   = 4'b0011 << ALUResultIn[1:0];
                wdata_rep = {2{WriteDataIn[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection uses the size/offset captured at issue, not the live EX/MEM inputs.
    always_comb begin
        ld_byte   = MemRData[{lo_q, 3'b000} +: 8];
        ld_half   = lo_q[1] ? MemRData[31:16] : MemRData[15:0];
        load_data = MemRData;
        case (sz_q)
            2'b00:   load_data = {{24{sgn_q & ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{16{sgn_q & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        timeout = (state_q == StBusy) && !MemAck && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
        cnt_d   = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if ((state_q == StBusy) && !MemAck && !timeout) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            StIdle: begin
                if (access && !misaligned) begin
                    stall   = 1'b1;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                stall = 1'b1;
                if (MemAck || timeout) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            dout_q  <= '0;
            berr_q  <= 1'b0;
            ld_q    <= 1'b0;
            sgn_q   <= 1'b0;
            sz_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            berr_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (access && misaligned) begin
                        dout_q <= '0;
                    end else if (access) begin
                        req_q   <= 1'b1;
                        we_q    <= MemWriteIn;
                        addr_q  <= {ALUResultIn[ADDR_WIDTH-1:2], 2'b00};
                        wdata_q <= wdata_rep;
                        be_q    <= byte_en;
                        ld_q    <= ~MemWriteIn;
                        sgn_q   <= MemSignedIn;
                        sz_q    <= MemSizeIn;
                        lo_q    <= ALUResultIn[1:0];
                    end
                end
                StBusy: begin
                    // Ack on the limit edge wins over the timeout.
                    if (MemAck) begin
                        req_q <= 1'b0;
                        if (ld_q) dout_q <= load_data;
                    end else if (timeout) begin
                        req_q  <= 1'b0;
                        berr_q <= 1'b1;
                        if (ld_q) dout_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign misalign_now  = (state_q == StIdle) && access && misaligned;
    assign Stall         = stall & ResetN;
    assign MisalignOut   = misalign_now & ResetN;
    assign DataMemoryOut = misalign_now ? 32'h0 : dout_q;
    assign BusError      = berr_q;
    assign MemReq        = req_q;
    assign MemWe         = we_q;
    assign MemAddr       = addr_q;
    assign MemWData      = wdata_q;
    assign MemByteEn     = be_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; expected load results go through a scoreboard queue.
module tb_mem_access_stage;

    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic        MemReadIn = 1'b0, MemWriteIn = 1'b0, MemSignedIn = 1'b0;
    logic [1:0]  MemSizeIn = 2'b00;
    logic [31:0] ALUResultIn = '0, WriteDataIn = '0;
    logic        Stall, MisalignOut, BusError, MemReq, MemWe;
    logic [31:0] DataMemoryOut, MemAddr, MemWData;
    logic [3:0]  MemByteEn;
    logic        MemAck = 1'b0;
    logic [31:0] MemRData = '0;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_dout;

    mem_access_stage #(
        .ADDR_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .Clock        (Clock),
        .ResetN       (ResetN),
        .MemReadIn    (MemReadIn),
        .MemWriteIn   (MemWriteIn),
        .MemSizeIn    (MemSizeIn),
        .MemSignedIn  (MemSignedIn),
        .ALUResultIn  (ALUResultIn),
        .WriteDataIn  (WriteDataIn),
        .Stall        (Stall),
        .DataMemoryOut(DataMemoryOut),
        .MisalignOut  (MisalignOut),
        .BusError     (BusError),
        .MemReq       (MemReq),
        .MemWe        (MemWe),
        .MemAddr      (MemAddr),
        .MemWData     (MemWData),
        .MemByteEn    (MemByteEn),
        .MemAck       (MemAck),
        .MemRData     (MemRData)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at posedge+#1 with the DUT idle; returns at posedge+#1 back in IDLE.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rdata, input int waits,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_dout, input int exp_stall);
        int stalls = 0;
        int cyc = 0;
        logic [31:0] want;
        sb_q.push_back(exp_dout);
        MemReadIn = rd; MemWriteIn = wr; MemSizeIn = sz; MemSignedIn = sg;
        ALUResultIn = addr; WriteDataIn = wd; MemRData = rdata; MemAck = 1'b0;
        #1;
        if (Stall) stalls++;
        @(posedge Clock); #1;
        chk({tag, "_req"}, 32'(MemReq), 32'd1);
        chk({tag, "_we"}, 32'(MemWe), 32'(wr));
        chk({tag, "_addr"}, MemAddr, {addr[31:2], 2'b00});
        chk({tag, "_be"}, 32'(MemByteEn), 32'(exp_be));
        chk({tag, "_wdata"}, MemWData, exp_wdata);
        while (MemReq && cyc <= waits + 2) begin
            MemAck = (cyc == waits);
            #1;
            if (Stall) stalls++;
            @(posedge Clock); #1;
            cyc++;
            if (MemReq) begin
                chk({tag, "_hold_addr"}, MemAddr, {addr[31:2], 2'b00});
                chk({tag, "_hold_be"}, 32'(MemByteEn), 32'(exp_be));
                chk({tag, "_hold_wdata"}, MemWData, exp_wdata);
            end
        end
        MemAck = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(cyc), 32'(waits + 1));
        chk({tag, "_req_drop"}, 32'(MemReq), 32'd0);
        chk({tag, "_done_stall"}, 32'(Stall), 32'd0);
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        chk({tag, "_berr"}, 32'(BusError), 32'd0);
        want = sb_q.pop_front();
        chk({tag, "_dout"}, DataMemoryOut, want);
        MemReadIn = 1'b0; MemWriteIn = 1'b0;
        @(posedge Clock); #1;
        chk({tag, "_idle_stall"}, 32'(Stall), 32'd0);
        chk({tag, "_dout_hold"}, DataMemoryOut, want);
        last_dout = want;
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_req", 32'(MemReq), 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_dout", DataMemoryOut, 32'd0);
        chk("rst_addr", MemAddr, 32'd0);
        chk("rst_be", 32'(MemByteEn), 32'd0);
        chk("rst_wdata", MemWData, 32'd0);
        chk("rst_berr", 32'(BusError), 32'd0);
        chk("rst_mis", 32'(MisalignOut), 32'd0);
        @(negedge Clock) ResetN = 1'b1;
        @(posedge Clock); #1;

        // Reset asserted while BUSY abandons the transaction
        MemReadIn = 1'b1; MemSizeIn = 2'b10; ALUResultIn = 32'h100; WriteDataIn = 32'h55AA55AA;
        #1;
        chk("rstb_idle_stall", 32'(Stall), 32'd1);
        @(posedge Clock); #1;
        chk("rstb_busy_req", 32'(MemReq), 32'd1);
        #2 ResetN = 1'b0;
        #1;
        chk("rstb_req", 32'(MemReq), 32'd0);
        chk("rstb_stall", 32'(Stall), 32'd0);
        chk("rstb_addr", MemAddr, 32'd0);
        chk("rstb_be", 32'(MemByteEn), 32'd0);
        chk("rstb_wdata", MemWData, 32'd0);
        chk("rstb_dout", DataMemoryOut, 32'd0);
        MemReadIn = 1'b0;
        @(negedge Clock) ResetN = 1'b1;
        @(posedge Clock); #1;
        chk("rstb_after_req", 32'(MemReq), 32'd0);
        chk("rstb_after_stall", 32'(Stall), 32'd0);
        last_dout = 32'h0;

        // Loads: word, signed/unsigned byte and half, one with wait states
        run_access("lw", 1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0,
                   4'b1111, 32'h0, 32'hDEADBEEF, 2);
        run_access("lb", 1, 0, 2'b00, 1, 32'h103, 32'h11223344, 32'h80FFFF7F, 0,
                   4'b1000, 32'h44444444, 32'hFFFFFF80, 2);
        run_access("lbu", 1, 0, 2'b00, 0, 32'h103, 32'h11223344, 32'h80FFFF7F, 0,
                   4'b1000, 32'h44444444, 32'h00000080, 2);
        run_access("lb_pos", 1, 0, 2'b00, 1, 32'h101, 32'h0, 32'h00007F00, 1,
                   4'b0010, 32'h0, 32'h0000007F, 3);
        run_access("lh", 1, 0, 2'b01, 1, 32'h102, 32'h0, 32'h80017FFF, 2,
                   4'b1100, 32'h0, 32'hFFFF8001, 4);
        run_access("lhu", 1, 0, 2'b01, 0, 32'h100, 32'h0, 32'h80017FFF, 0,
                   4'b0011, 32'h0, 32'h00007FFF, 2);

        // Stores leave DataMemoryOut alone; read+write together is a store
        run_access("sh", 0, 1, 2'b01, 0, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 3,
                   4'b1100, 32'hABCDABCD, last_dout, 5);
        run_access("sb_rw", 1, 1, 2'b00, 1, 32'h101, 32'h000000A5, 32'h12345678, 0,
                   4'b0010, 32'hA5A5A5A5, last_dout, 2);
        run_access("sw", 0, 1, 2'b11, 0, 32'h208, 32'hCAFEBABE, 32'h0, 1,
                   4'b1111, 32'hCAFEBABE, last_dout, 3);

        // Ack while idle is ignored
        MemAck = 1'b1;
        #1;
        chk("ack_idle_stall", 32'(Stall), 32'd0);
        @(posedge Clock); #1;
        MemAck = 1'b0;
        chk("ack_idle_req", 32'(MemReq), 32'd0);
        chk("ack_idle_dout", DataMemoryOut, last_dout);

        // Misaligned word load: suppressed, pulse, data forced to 0
        MemReadIn = 1'b1; MemSizeIn = 2'b10; ALUResultIn = 32'h101;
        #1;
        chk("mis_lw_stall", 32'(Stall), 32'd0);
        chk("mis_lw_pulse", 32'(MisalignOut), 32'd1);
        chk("mis_lw_dout", DataMemoryOut, 32'd0);
        @(posedge Clock); #1;
        MemReadIn = 1'b0;
        #1;
        chk("mis_lw_noreq", 32'(MemReq), 32'd0);
        chk("mis_lw_pulse_end", 32'(MisalignOut), 32'd0);
        chk("mis_lw_dout_hold", DataMemoryOut, 32'd0);

        // Misaligned half store
        MemWriteIn = 1'b1; MemSizeIn = 2'b01; ALUResultIn = 32'h103;
        #1;
        chk("mis_sh_stall", 32'(Stall), 32'd0);
        chk("mis_sh_pulse", 32'(MisalignOut), 32'd1);
        @(posedge Clock); #1;
        MemWriteIn = 1'b0;
        #1;
        chk("mis_sh_noreq", 32'(MemReq), 32'd0);
        chk("mis_sh_pulse_end", 32'(MisalignOut), 32'd0);
        @(posedge Clock); #1;
        last_dout = 32'h0;

        run_access("lw_again", 1, 0, 2'b10, 0, 32'h10C, 32'h0, 32'h2468ACE0, 0,
                   4'b1111, 32'h0, 32'h2468ACE0, 2);

`ifdef MEM_STAGE_TIMEOUT_EN
        // No ack: abort after 4 BUSY cycles
        MemReadIn = 1'b1; MemSizeIn = 2'b10; ALUResultIn = 32'h200; MemRData = 32'hCAFEF00D;
        MemAck = 1'b0;
        sb_q.push_back(32'h0);
        @(posedge Clock); #1;
        chk("to_req", 32'(MemReq), 32'd1);
        for (int i = 1; i < 4; i++) begin
            @(posedge Clock); #1;
            chk("to_wait_req", 32'(MemReq), 32'd1);
            chk("to_wait_berr", 32'(BusError), 32'd0);
        end
        @(posedge Clock); #1;
        chk("to_req_drop", 32'(MemReq), 32'd0);
        chk("to_berr", 32'(BusError), 32'd1);
        chk("to_stall", 32'(Stall), 32'd0);
        chk("to_dout", DataMemoryOut, sb_q.pop_front());
        MemReadIn = 1'b0;
        @(posedge Clock); #1;
        chk("to_berr_pulse", 32'(BusError), 32'd0);
        chk("to_idle_stall", 32'(Stall), 32'd0);
        last_dout = 32'h0;
        // Ack in the 4th BUSY cycle beats the timeout
        run_access("to_ack4", 1, 0, 2'b10, 0, 32'h204, 32'h0, 32'h13579BDF, 3,
                   4'b1111, 32'h0, 32'h13579BDF, 5);
`else
        // Without the timeout a long wait simply completes
        run_access("long_wait", 1, 0, 2'b10, 0, 32'h204, 32'h0, 32'h13579BDF, 20,
                   4'b1111, 32'h0, 32'h13579BDF, 22);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
